uart_rx_buffer: RTL and testbench
=================================

// Module: uart_rx_buffer
//
// PURPOSE
// - Receive-side byte buffer placed directly downstream of the UART receiver.
// - Captures each received byte (one-cycle valid strobe + 8-bit data) into a FIFO.
// - Exposes a show-ahead read port to the bus register block.
// - Generates watermark, overflow and character-timeout status for interrupt logic.
//
// PARAMETERS
// - DEPTH  16  FIFO entries; power of two, 4..256
// - AW     $clog2(DEPTH), localparam (not overridable); pointer width
//
// PORTS
// - clk_i        in   1     single clock for the whole block
// - rst_ni       in   1     reset, asynchronous assert, active-low
// - rx_valid_i   in   1     one-cycle strobe from receiver: byte complete
// - rx_byte_i    in   8     received byte; sampled only when rx_valid_i=1
// - fifo_clr_i   in   1     synchronous flush: empties FIFO, clears all flags
// - rd_en_i      in   1     pop head entry (bus read of RX data register)
// - rd_data_o    out  8     head entry; valid only while empty_o=0
// - empty_o      out  1     FIFO holds 0 entries
// - full_o       out  1     FIFO holds DEPTH entries
// - level_o      out  AW+1  current entry count, 0..DEPTH
// - watermark_i  in   AW+1  threshold for wm_o; 0 disables
// - wm_o         out  1     level_o >= watermark_i && watermark_i != 0
// - ovf_o        out  1     sticky: byte dropped because FIFO was full
// - ovf_clr_i    in   1     clears ovf_o
// - timeout_i    in   24    idle clocks before timeout; 0 disables
// - timeout_o    out  1     sticky: data waiting and no push/pop for timeout_i clocks
//
// BEHAVIOUR
// - Reset (rst_ni=0, async):
//   - pointers, level, ovf, timeout flag and idle counter all go to 0
//   - empty_o=1; full_o=0; wm_o=0; rd_data_o=0
// - Storage:
//   - write pointer and read pointer, AW bits each, wrap modulo DEPTH
//   - level counter is AW+1 bits and is the source of empty_o, full_o and level_o
// - Push: rx_valid_i=1 and not full → write mem[wptr] = rx_byte_i, wptr+1, level+1.
// - Pop: rd_en_i=1 and not empty → rptr+1, level-1.
//   - rd_data_o is mem[rptr] combinationally (show-ahead).
//   - rd_data_o updates the cycle after a pop.
// - Latency: a byte pushed in cycle N is visible on rd_data_o with empty_o=0 in cycle N+1.
// - Simultaneous push and pop:
//   - Non-empty, non-full: both occur, level unchanged.
//   - Full: both occur (pop frees the slot this cycle), level stays DEPTH, no overflow.
//   - Empty: push only; rd_en_i is ignored.
// - Push while full, no pop:
//   - byte discarded; FIFO contents unchanged
//   - ovf_o=1 from next cycle
// - Pop while empty: ignored; no pointer or level change.
// - ovf_o clearing:
//   - cleared by ovf_clr_i or fifo_clr_i
//   - a new overflow in the same cycle as ovf_clr_i wins (ovf_o stays 1)
// - Flush (fifo_clr_i): overrides push and pop in the same cycle.
//   - wptr=rptr=0, level=0
//   - ovf_o=0, timeout_o=0, idle counter=0
//   - a byte arriving that cycle is lost; it does not set ovf_o
// - Timeout: 24-bit idle counter.
//   - resets to 0 on any push, any pop, flush, or when level=0
//   - otherwise increments each clock while timeout_i != 0
//   - when counter == timeout_i-1, timeout_o sets next cycle and the counter saturates
//   - timeout_o is cleared by a pop or flush, not by a push
//   - timeout_i changed mid-count: compare against the new value; no retroactive fire
// - wm_o: combinational from level_o and watermark_i; no hysteresis.
// - All outputs are registered or derived from registers only; no input→output combinational path except wm_o via watermark_i.
//
// STRUCTURE
// - Shared package/include, constants only:
//   - UART_DATA_W=8
//   - UART_TO_W=24
// - One sub-module: uart_fifo_mem
//   - DEPTH x 8 flop array
//   - one synchronous write port, one asynchronous read port
//   - no reset on the array
// - Pointer, level, flag and timeout logic live in uart_rx_buffer.
//
// TESTING
// - Push 0xA5 then 0x3C, no reads:
//   - level_o=2, rd_data_o=0xA5
//   - pop → rd_data_o=0x3C; pop → empty_o=1
// - Push 17 bytes 0x00..0x10 with DEPTH=16:
//   - full_o=1, ovf_o=1
//   - 16 pops return 0x00..0x0F in order; 0x10 is absent
// - At full, rx_valid_i and rd_en_i in the same cycle:
//   - level_o stays 16, ovf_o stays 0
//   - next byte out is the old second entry
// - timeout_i=100, push one byte, then idle:
//   - timeout_o rises exactly 100 cycles after the push
//   - a pop clears it; with FIFO empty it never rises
// - watermark_i=4:
//   - 3 pushes → wm_o=0; 4th push → wm_o=1; one pop → wm_o=0
// - Mid-stream events:
//   - fifo_clr_i coincident with push: level_o=0, ovf_o=0
//   - rst_ni pulsed low mid-stream: all outputs hit reset values asynchronously

Source files
------------

// File: rtl/uart_rx_buffer_pkg.sv
// Shared widths for the UART receive buffer: data byte and idle-timeout counter.
// Constants only; no logic.
package uart_rx_buffer_pkg;
  localparam int UART_DATA_W = 8;
  localparam int UART_TO_W   = 24;
endpackage

// File: rtl/uart_rx_buffer_if.sv
// Receiver push strobe plus show-ahead read port and fill status of the RX buffer.
// master = receiver/bus side, slave = the buffer itself.
interface uart_rx_buffer_if
  import uart_rx_buffer_pkg::*;
#(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic                   rx_valid_i;
  logic [UART_DATA_W-1:0] rx_byte_i;
  logic                   rd_en_i;
  logic [UART_DATA_W-1:0] rd_data_o;
  logic                   empty_o;
  logic                   full_o;
  logic [AW:0]            level_o;

  modport master (
    output rx_valid_i, rx_byte_i, rd_en_i,
    input  rd_data_o, empty_o, full_o, level_o
  );

  modport slave (
    input  rx_valid_i, rx_byte_i, rd_en_i,
    output rd_data_o, empty_o, full_o, level_o
  );
endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x 8 flop array: one synchronous write port, one asynchronous read port.
// Write lands on the clock edge; read is combinational; no reset on the array.
module uart_fifo_mem
  import uart_rx_buffer_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   we_i,
  input  logic [AW-1:0]          waddr_i,
  input  logic [UART_DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]          raddr_i,
  output logic [UART_DATA_W-1:0] rdata_o
);
  logic [UART_DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/uart_rx_buffer.sv
// UART RX byte FIFO with show-ahead read, watermark, sticky overflow and idle timeout.
// Push visible on rd_data_o next cycle; no backpressure: bytes arriving while full are dropped.
module uart_rx_buffer
  import uart_rx_buffer_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  uart_rx_buffer_if.slave      bus,
  input  logic                 fifo_clr_i,
  input  logic [AW:0]          watermark_i,
  output logic                 wm_o,
  output logic                 ovf_o,
  input  logic                 ovf_clr_i,
  input  logic [UART_TO_W-1:0] timeout_i,
  output logic                 timeout_o
);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]            level_q, level_d;
  logic                   ovf_q, ovf_d, to_q, to_d;
  logic [UART_TO_W-1:0]   idle_q, idle_d;
  logic                   full, empty, push, pop, ovf_set, to_hit;
  logic [UART_DATA_W-1:0] mem_rdata;

  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);

  // When full, a coincident pop frees the slot, so the push is still accepted.
  assign push    = bus.rx_valid_i & (~full | bus.rd_en_i) & ~fifo_clr_i;
  assign pop     = bus.rd_en_i & ~empty & ~fifo_clr_i;
  assign ovf_set = bus.rx_valid_i & full & ~bus.rd_en_i & ~fifo_clr_i;
  assign to_hit  = (timeout_i != '0) && (idle_q == timeout_i - 1'b1);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    to_d    = to_q;
    idle_d  = idle_q;
    if (fifo_clr_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      ovf_d   = 1'b0;
      to_d    = 1'b0;
      idle_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      if (push && !pop)      level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;

      if (ovf_set)        ovf_d = 1'b1;
      else if (ovf_clr_i) ovf_d = 1'b0;

      // Counter holds once it reaches the threshold, or at all-ones if the
      // threshold was lowered below the current count.
      if (push || pop || empty) begin
        idle_d = '0;
      end else if (timeout_i != '0) begin
        if (to_hit)             to_d   = 1'b1;
        else if (idle_q != '1)  idle_d = idle_q + 1'b1;
      end
      if (pop) to_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      to_q    <= 1'b0;
      idle_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      to_q    <= to_d;
      idle_q  <= idle_d;
    end
  end

  uart_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk_i   (clk_i),
    .we_i    (push),
    .waddr_i (wptr_q),
    .wdata_i (bus.rx_byte_i),
    .raddr_i (rptr_q),
    .rdata_o (mem_rdata)
  );

  // Gated so the unreset array never leaks onto the bus while empty.
  assign bus.rd_data_o = empty ? '0 : mem_rdata;
  assign bus.empty_o   = empty;
  assign bus.full_o    = full;
  assign bus.level_o   = level_q;
  assign wm_o          = (watermark_i != '0) && (level_q >= watermark_i);
  assign ovf_o         = ovf_q;
  assign timeout_o     = to_q;
endmodule

// File: tb/tb_uart_rx_buffer.sv
module tb_uart_rx_buffer;
  import uart_rx_buffer_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 fifo_clr, ovf_clr;
  logic [AW:0]          watermark;
  logic                 wm, ovf, tout;
  logic [UART_TO_W-1:0] timeout;

  uart_rx_buffer_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus.slave),
    .fifo_clr_i  (fifo_clr),
    .watermark_i (watermark),
    .wm_o        (wm),
    .ovf_o       (ovf),
    .ovf_clr_i   (ovf_clr),
    .timeout_i   (timeout),
    .timeout_o   (tout)
  );

  always #5 clk = ~clk;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] sb[$];
  bit         ovf_m  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, ".level"}, 32'(bus.level_o), 32'(sb.size()));
    chk({tag, ".empty"}, 32'(bus.empty_o), 32'(sb.size() == 0));
    chk({tag, ".full"},  32'(bus.full_o),  32'(sb.size() == DEPTH));
    chk({tag, ".ovf"},   32'(ovf),         32'(ovf_m));
  endtask

  // One clock of stimulus, entered and left at a falling edge. The scoreboard
  // is updated from its own view of occupancy; pops compare the head.
  task automatic cyc(input bit v, input logic [7:0] b, input bit r, input bit c, input bit oc);
    bit full_m, empty_m, ovf_new;
    full_m  = (sb.size() == DEPTH);
    empty_m = (sb.size() == 0);
    if (c) begin
      sb.delete();
      ovf_m = 1'b0;
    end else begin
      if (r && !empty_m) begin
        chk("pop_data", 32'(bus.rd_data_o), 32'(sb[0]));
        void'(sb.pop_front());
      end
      ovf_new = v && full_m && !r;
      if (v && !ovf_new) sb.push_back(b);
      if (ovf_new)  ovf_m = 1'b1;
      else if (oc)  ovf_m = 1'b0;
    end
    bus.rx_valid_i = v;
    bus.rx_byte_i  = b;
    bus.rd_en_i    = r;
    fifo_clr       = c;
    ovf_clr        = oc;
    @(negedge clk);
    bus.rx_valid_i = 1'b0;
    bus.rx_byte_i  = 8'h00;
    bus.rd_en_i    = 1'b0;
    fifo_clr       = 1'b0;
    ovf_clr        = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    cyc(1'b1, b, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int rise;
    rst_n          = 1'b0;
    bus.rx_valid_i = 1'b0;
    bus.rx_byte_i  = 8'h00;
    bus.rd_en_i    = 1'b0;
    fifo_clr       = 1'b0;
    ovf_clr        = 1'b0;
    watermark      = '0;
    timeout        = '0;

    repeat (3) @(negedge clk);
    chk_status("reset");
    chk("reset.rd_data", 32'(bus.rd_data_o), 32'h0);
    chk("reset.wm",      32'(wm),            32'h0);
    chk("reset.tout",    32'(tout),          32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two bytes, show-ahead head, pops in order
    push(8'hA5);
    chk("lat.empty", 32'(bus.empty_o),   32'h0);
    chk("lat.head",  32'(bus.rd_data_o), 32'hA5);
    push(8'h3C);
    chk_status("two");
    chk("two.head", 32'(bus.rd_data_o), 32'hA5);
    pop();
    chk("two.next", 32'(bus.rd_data_o), 32'h3C);
    pop();
    chk_status("two_drained");

    // Overfill by one: 0x10 dropped, overflow sticky
    for (int i = 0; i <= DEPTH; i++) push(8'(i));
    chk_status("overfill");
    // New overflow in the same cycle as the clear keeps ovf set
    cyc(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
    chk_status("ovf_vs_clr");
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk_status("ovf_clr");
    for (int i = 0; i < DEPTH; i++) pop();
    chk_status("overfill_drained");
    pop();
    chk_status("pop_empty");

    // Full with coincident push and pop
    for (int i = 0; i < DEPTH; i++) push(8'(8'h20 + i));
    cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    chk_status("full_pushpop");
    chk("full_pushpop.head", 32'(bus.rd_data_o), 32'h21);
    for (int i = 0; i < DEPTH; i++) pop();
    chk_status("full_drained");

    // Idle timeout of 100 clocks after a single push
    timeout = 24'd100;
    push(8'h42);
    rise = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (tout) begin
        rise = i;
        break;
      end
    end
    chk("to.rise_cycle", 32'(rise), 32'd100);
    push(8'h43);
    chk("to.push_keeps", 32'(tout), 32'h1);
    pop();
    chk("to.pop_clears", 32'(tout), 32'h0);
    pop();
    repeat (150) @(negedge clk);
    chk("to.empty_quiet", 32'(tout), 32'h0);
    timeout = '0;

    // Watermark at 4
    watermark = (AW+1)'(4);
    for (int i = 0; i < 3; i++) push(8'(8'h60 + i));
    chk("wm.three", 32'(wm), 32'h0);
    push(8'h63);
    chk("wm.four", 32'(wm), 32'h1);
    pop();
    chk("wm.pop", 32'(wm), 32'h0);
    for (int i = 0; i < 3; i++) pop();

    // Flush coincident with a push while overflowed
    for (int i = 0; i <= DEPTH; i++) push(8'(8'h80 + i));
    chk_status("pre_flush");
    cyc(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    chk_status("flush");
    chk("flush.rd_data", 32'(bus.rd_data_o), 32'h0);

    // Asynchronous reset between clock edges
    watermark = (AW+1)'(2);
    for (int i = 0; i <= DEPTH; i++) push(8'(8'hC0 + i));
    chk("pre_rst.wm", 32'(wm), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    ovf_m = 1'b0;
    chk_status("async_rst");
    chk("async_rst.rd_data", 32'(bus.rd_data_o), 32'h0);
    chk("async_rst.wm",      32'(wm),            32'h0);
    chk("async_rst.tout",    32'(tout),          32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    watermark = '0;
    @(negedge clk);
    push(8'h77);
    chk("post_rst.head", 32'(bus.rd_data_o), 32'h77);
    pop();
    chk_status("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
